// File: rtl/common_types_pkg.sv
// rtl/common_types_pkg.sv - shared AHB-Lite and arbiter types for the fetch/data bus arbiter
package common_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  function automatic logic [2:0] size_to_hsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - two-requester (fetch/data) AHB-Lite master arbiter, one transfer at a time
// Define ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module ahb_arbiter
  import common_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       i_req,
  input  word_t      i_addr,
  output word_t      i_rdata,
  output logic       i_done,
  output logic       i_err,
  input  logic       d_req,
  input  logic       d_wen,
  input  word_t      d_addr,
  input  logic [1:0] d_size,
  input  word_t      d_wdata,
  output word_t      d_rdata,
  output logic       d_done,
  output logic       d_err,
  output word_t      haddr,
  output htrans_t    htrans,
  output logic       hwrite,
  output logic [2:0] hsize,
  output word_t      hwdata,
  input  word_t      hrdata,
  input  logic       hready,
  input  logic       hresp
);

  arb_state_t state, state_next;
  arb_grant_t grant;
  word_t      addr_q;
  word_t      wdata_q;
  logic       wen_q;
  logic [2:0] size_q;

  logic i_pend, d_pend, any_pend, pick_d, xfer_end;

  // A requester whose done is showing this cycle has not yet seen it, so its
  // still-high req must not start a second transfer.
  assign i_pend   = i_req & ~i_done;
  assign d_pend   = d_req & ~d_done;
  assign any_pend = i_pend | d_pend;
  assign xfer_end = (state == ARB_DATA) && hready;

`ifdef ARB_RR_EN
  arb_grant_t rr_ptr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr <= GRANT_D;
    end else if (xfer_end) begin
      rr_ptr <= (grant == GRANT_D) ? GRANT_I : GRANT_D;
    end
  end

  assign pick_d = d_pend & (~i_pend | (rr_ptr == GRANT_D));
`else
  assign pick_d = d_pend;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grant   <= GRANT_D;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      size_q  <= HSIZE_BYTE;
    end else if ((state == ARB_IDLE) && any_pend) begin
      grant   <= pick_d ? GRANT_D : GRANT_I;
      addr_q  <= pick_d ? d_addr : i_addr;
      wdata_q <= pick_d ? d_wdata : '0;
      wen_q   <= pick_d & d_wen;
      size_q  <= pick_d ? size_to_hsize(d_size) : HSIZE_WORD;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_err   <= 1'b0;
      d_err   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_done <= xfer_end && (grant == GRANT_I);
      d_done <= xfer_end && (grant == GRANT_D);
      i_err  <= xfer_end && (grant == GRANT_I) && hresp;
      d_err  <= xfer_end && (grant == GRANT_D) && hresp;
      if (xfer_end && (grant == GRANT_I)) begin
        i_rdata <= hrdata;
      end
      if (xfer_end && (grant == GRANT_D)) begin
        d_rdata <= hrdata;
      end
    end
  end

  // Address and data phases never overlap, so bus outputs are simply decoded from state.
  always_comb begin
    state_next = state;
    htrans     = HTRANS_IDLE;
    haddr      = '0;
    hwrite     = 1'b0;
    hsize      = HSIZE_BYTE;
    hwdata     = '0;
    unique case (state)
      ARB_IDLE: begin
        if (any_pend) begin
          state_next = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        htrans = HTRANS_NONSEQ;
        haddr  = addr_q;
        hwrite = wen_q;
        hsize  = size_q;
        if (hready) begin
          state_next = ARB_DATA;
        end
      end
      ARB_DATA: begin
        hwdata = wdata_q;
        if (hready) begin
          state_next = ARB_IDLE;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - self-checking bench for ahb_arbiter (directed table, random episodes, reset cases)
module tb_ahb_arbiter;
  import common_types_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       i_req;
  word_t      i_addr;
  word_t      i_rdata;
  logic       i_done;
  logic       i_err;
  logic       d_req;
  logic       d_wen;
  word_t      d_addr;
  logic [1:0] d_size;
  word_t      d_wdata;
  word_t      d_rdata;
  logic       d_done;
  logic       d_err;
  word_t      haddr;
  htrans_t    htrans;
  logic       hwrite;
  logic [2:0] hsize;
  word_t      hwdata;
  word_t      hrdata;
  logic       hready;
  logic       hresp;

  int n_checks = 0;
  int n_fail   = 0;
  bit prefer_d = 1'b1;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  ahb_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 CLK = ~CLK;

  // One episode: requests raised together in cycle 0; slot 0/1 = first/second transfer served.
  typedef struct packed {
    bit         a_i;
    bit         a_d;
    bit         d_wen;
    logic [1:0] d_size;
    word_t      ia;
    word_t      da;
    word_t      dw;
    int         w0;
    int         w1;
    bit         e0;
    bit         e1;
    word_t      rd0;
    word_t      rd1;
    bit         drop_d;
    bit         first_d;
    int         exp_i;
    int         exp_d;
  } ep_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic ep_t mk(bit a_i, bit a_d, bit wen, logic [1:0] sz, word_t ia, word_t da,
                             word_t dw, int w0, int w1, bit e0, bit e1, word_t rd0, word_t rd1,
                             bit drop, bit first_d, int exp_i, int exp_d);
    ep_t r;
    r.a_i = a_i; r.a_d = a_d; r.d_wen = wen; r.d_size = sz;
    r.ia = ia; r.da = da; r.dw = dw; r.w0 = w0; r.w1 = w1; r.e0 = e0; r.e1 = e1;
    r.rd0 = rd0; r.rd1 = rd1; r.drop_d = drop; r.first_d = first_d;
    r.exp_i = exp_i; r.exp_d = exp_d;
    return r;
  endfunction

  // Reference: zero-wait transfer takes 3 cycles from request to done, each wait state adds one,
  // and the second requester starts in the cycle its predecessor's done is shown.
  function automatic ep_t predict(ep_t e);
    ep_t r;
    int  t0, t1;
    r = e;
    t0 = 3 + e.w0;
    t1 = t0 + 3 + e.w1;
    r.first_d = e.a_d && (!e.a_i || !RR || prefer_d);
    r.exp_d = !e.a_d ? -1 : (r.first_d ? t0 : t1);
    r.exp_i = !e.a_i ? -1 : (r.first_d ? t1 : t0);
    return r;
  endfunction

  task automatic run_ep(input ep_t e, input string tag);
    int    cyc, n_xfer, k_a, k_d, rem, both, nonseq, i_cnt, d_cnt, i_at, d_at, last;
    int    i_slot, d_slot;
    bit    in_data, drop_i, drop_d, last_d, i_er, d_er;
    word_t i_rd, d_rd;
    word_t cap_a [2];
    word_t cap_wd[2];
    logic  cap_w [2];
    logic [2:0] cap_s[2];
    word_t rdv[2];
    int    wv [2];
    bit    ev [2];
    cap_a = '{default: '0}; cap_wd = '{default: '0};
    cap_w = '{default: 1'b0}; cap_s = '{default: 3'd0};
    rdv[0] = e.rd0; rdv[1] = e.rd1;
    wv[0]  = e.w0;  wv[1]  = e.w1;
    ev[0]  = e.e0;  ev[1]  = e.e1;
    n_xfer = int'(e.a_i) + int'(e.a_d);
    i_slot = e.first_d ? 1 : 0;
    d_slot = e.first_d ? 0 : 1;
    cyc = 0; k_a = 0; k_d = 0; rem = 0; both = 0; nonseq = 0; i_cnt = 0; d_cnt = 0;
    i_at = -1; d_at = -1; last = 0; in_data = 0; drop_i = 0; drop_d = 0;
    i_er = 0; d_er = 0; i_rd = '0; d_rd = '0;
    i_req = e.a_i; i_addr = e.ia;
    d_req = e.a_d; d_wen = e.d_wen; d_addr = e.da; d_size = e.d_size; d_wdata = e.dw;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    while (cyc < 60) begin
      @(negedge CLK);
      cyc++;
      if (drop_i) i_req = 1'b0;
      if (drop_d) d_req = 1'b0;
      if (e.drop_d && cyc == 1) d_req = 1'b0;
      if (i_done && d_done) both++;
      if (i_done) begin
        i_cnt++; drop_i = 1; last = cyc;
        if (i_at < 0) begin i_at = cyc; i_rd = i_rdata; i_er = i_err; end
      end
      if (d_done) begin
        d_cnt++; drop_d = 1; last = cyc;
        if (d_at < 0) begin d_at = cyc; d_rd = d_rdata; d_er = d_err; end
      end
      hready = 1'b1; hresp = 1'b0; hrdata = '0;
      if (in_data && k_d < 2) begin
        hresp = ev[k_d]; hrdata = rdv[k_d]; cap_wd[k_d] = hwdata;
        if (rem == 0) begin in_data = 0; k_d++; end
        else begin hready = 1'b0; rem--; end
      end
      if (htrans == HTRANS_NONSEQ) begin
        nonseq++;
        if (k_a < 2) begin
          cap_a[k_a] = haddr; cap_w[k_a] = hwrite; cap_s[k_a] = hsize; rem = wv[k_a]; k_a++;
        end
        in_data = 1;
      end
      if (i_cnt + d_cnt >= n_xfer && cyc >= last + 3) break;
    end
    chk({tag, ".i_done_cycle"}, i_at, e.exp_i);
    chk({tag, ".d_done_cycle"}, d_at, e.exp_d);
    chk({tag, ".i_done_count"}, i_cnt, 32'(e.a_i));
    chk({tag, ".d_done_count"}, d_cnt, 32'(e.a_d));
    chk({tag, ".dual_done"}, both, 0);
    chk({tag, ".nonseq_cycles"}, nonseq, n_xfer);
    if (e.a_i) begin
      chk({tag, ".i_rdata"}, i_rd, rdv[i_slot]);
      chk({tag, ".i_err"}, 32'(i_er), 32'(ev[i_slot]));
      chk({tag, ".i_haddr"}, cap_a[i_slot], e.ia);
      chk({tag, ".i_hwrite_hsize"}, 32'({cap_w[i_slot], cap_s[i_slot]}), 32'({1'b0, HSIZE_WORD}));
    end
    if (e.a_d) begin
      chk({tag, ".d_err"}, 32'(d_er), 32'(ev[d_slot]));
      chk({tag, ".d_haddr"}, cap_a[d_slot], e.da);
      chk({tag, ".d_hwrite_hsize"}, 32'({cap_w[d_slot], cap_s[d_slot]}),
          32'({e.d_wen, 1'b0, e.d_size}));
      if (e.d_wen) chk({tag, ".d_hwdata"}, cap_wd[d_slot], e.dw);
      else         chk({tag, ".d_rdata"}, d_rd, rdv[d_slot]);
    end
    last_d = (n_xfer == 2) ? !e.first_d : e.a_d;
    prefer_d = !last_d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ep_t tbl[8];
    ep_t e;
    int  sel, cnt;

    tbl[0] = mk(1, 0, 0, 2'd0, 32'h0000_0100, 32'h0, 32'h0, 0, 0, 0, 0,
                32'h0010_0093, 32'h0, 0, 0, 3, -1);
    tbl[1] = mk(0, 1, 1, 2'd0, 32'h0, 32'h2000_0003, 32'h0000_00AB, 0, 0, 0, 0,
                32'h0, 32'h0, 0, 1, -1, 3);
    tbl[2] = mk(0, 1, 0, 2'd2, 32'h0, 32'h2000_0010, 32'h0, 2, 0, 0, 0,
                32'hCAFE_F00D, 32'h0, 0, 1, -1, 5);
    tbl[3] = mk(0, 1, 0, 2'd2, 32'h0, 32'h2000_0020, 32'h0, 1, 0, 1, 0,
                32'hDEAD_BEEF, 32'h0, 0, 1, -1, 4);
    tbl[4] = mk(1, 0, 0, 2'd0, 32'h0000_0104, 32'h0, 32'h0, 0, 0, 0, 0,
                32'h0000_0013, 32'h0, 0, 0, 3, -1);
    tbl[5] = mk(1, 1, 0, 2'd2, 32'h0000_0108, 32'h2000_0040, 32'h0, 0, 0, 0, 0,
                32'h1111_2222, 32'h3333_4444, 0, 1, 6, 3);
    tbl[6] = mk(1, 1, 1, 2'd1, 32'h0000_010C, 32'h2000_0102, 32'h0000_1234, 1, 2, 0, 0,
                32'h0, 32'h5555_6666, 0, 1, 9, 4);
    tbl[7] = mk(0, 1, 0, 2'd2, 32'h0, 32'h2000_0080, 32'h0, 1, 0, 0, 0,
                32'h7777_8888, 32'h0, 1, 1, -1, 4);

    nRST = 1'b0;
    i_req = 1'b1; i_addr = '1;
    d_req = 1'b1; d_wen = 1'b1; d_addr = '1; d_size = 2'd2; d_wdata = '1;
    hready = 1'b1; hresp = 1'b1; hrdata = '1;
    repeat (3) @(negedge CLK);
    chk("reset.htrans", 32'(htrans), 32'(HTRANS_IDLE));
    chk("reset.haddr", haddr, 32'h0);
    chk("reset.hwrite_hsize", 32'({hwrite, hsize}), 32'h0);
    chk("reset.hwdata", hwdata, 32'h0);
    chk("reset.i_rdata", i_rdata, 32'h0);
    chk("reset.d_rdata", d_rdata, 32'h0);
    chk("reset.done_err", 32'({i_done, i_err, d_done, d_err}), 32'h0);
    i_req = 1'b0; d_req = 1'b0; hresp = 1'b0; hrdata = '0;
    nRST = 1'b1;
    prefer_d = 1'b1;
    @(negedge CLK);

    for (int n = 0; n < 8; n++) begin
      run_ep(tbl[n], $sformatf("vec%0d", n));
    end

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(2, 0));
      e = '0;
      e.a_i = (sel != 1);
      e.a_d = (sel != 0);
      e.d_wen = 1'($urandom_range(1, 0));
      e.d_size = 2'($urandom_range(2, 0));
      e.ia = $urandom & 32'hFFFF_FFFC;
      e.da = $urandom;
      e.dw = $urandom;
      e.w0 = int'($urandom_range(3, 0));
      e.w1 = int'($urandom_range(3, 0));
      e.e0 = ($urandom_range(7, 0) == 0);
      e.e1 = ($urandom_range(7, 0) == 0);
      e.rd0 = $urandom;
      e.rd1 = $urandom;
      e = predict(e);
      run_ep(e, $sformatf("rnd%0d", n));
    end

    // Reset during the data phase of a write abandons it with no done.
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h2000_0200; d_size = 2'd2; d_wdata = 32'h5555_AAAA;
    hready = 1'b1; hresp = 1'b0;
    @(negedge CLK);
    chk("rstmid.addr_phase", 32'(htrans), 32'(HTRANS_NONSEQ));
    @(negedge CLK);
    chk("rstmid.data_hwdata", hwdata, 32'h5555_AAAA);
    hready = 1'b0;
    nRST = 1'b0; d_req = 1'b0;
    #1;
    chk("rstmid.htrans", 32'(htrans), 32'(HTRANS_IDLE));
    chk("rstmid.hwdata", hwdata, 32'h0);
    @(negedge CLK);
    nRST = 1'b1; hready = 1'b1;
    prefer_d = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge CLK);
      if (i_done || d_done || htrans != HTRANS_IDLE) cnt++;
    end
    chk("rstmid.quiet_after_release", cnt, 0);

    e = mk(1, 1, 0, 2'd2, 32'h0000_0200, 32'h2000_0300, 32'h0, 0, 1, 0, 0,
           32'hA1A2_A3A4, 32'hB1B2_B3B4, 0, 0, 0, 0);
    e = predict(e);
    run_ep(e, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-002 Port nRST, input, 1: asynchronous, active-low reset.
REQ-003 Port i_req, input, 1: instruction-fetch request; held until i_done.
REQ-004 Port i_addr, input, word_t: fetch address; word-aligned, word-size read.
REQ-005 Port i_rdata, output, word_t: fetch read data; valid when i_done=1.
REQ-006 Port i_done, output, 1: fetch transfer complete, one-cycle pulse.
REQ-007 Port i_err, output, 1: fetch bus error, valid with i_done.
REQ-008 Port d_req, input, 1: data request; held until d_done.
REQ-009 Port d_wen, input, 1: 1=write, 0=read.
REQ-010 Port d_addr, input, word_t: data address.
REQ-011 Port d_size, input, 2: 0=byte, 1=half, 2=word.
REQ-012 Port d_wdata, input, word_t: write data.
REQ-013 Port d_rdata, output, word_t: data read value; valid when d_done=1.
REQ-014 Port d_done, output, 1: data transfer complete, one-cycle pulse.
REQ-015 Port d_err, output, 1: data bus error, valid with d_done.
REQ-016 Port haddr, output, word_t: AHB-Lite address.
REQ-017 Port htrans, output, htrans_t: AHB-Lite transfer type; only IDLE or NONSEQ.
REQ-018 Port hwrite, output, 1: AHB-Lite write.
REQ-019 Port hsize, output, 3: AHB-Lite size; upper bit 0.
REQ-020 Port hwdata, output, word_t: AHB-Lite write data.
REQ-021 Port hrdata, input, word_t: AHB-Lite read data.
REQ-022 Port hready, input, 1: AHB-Lite transfer ready.
REQ-023 Port hresp, input, 1: AHB-Lite error response.

Function
REQ-024 FSM states SHALL be ARB_IDLE, ARB_ADDR, ARB_DATA. ARB_IDLE->ARB_ADDR when any request is present. ARB_ADDR->ARB_DATA on hready=1. ARB_DATA->ARB_IDLE on hready=1.
REQ-025 In ARB_IDLE, the grant SHALL be latched together with the granted requester's addr, size, wen and wdata.
REQ-026 Without ARB_RR_EN, d_req SHALL win over i_req when both are asserted.
REQ-027 The block SHALL drive htrans=NONSEQ only in ARB_ADDR, and IDLE in all other states. There is no address/data phase overlap.
REQ-028 In ARB_ADDR, haddr, hwrite and hsize SHALL reflect the latched request. For instruction fetches, hsize=word and hwrite=0.
REQ-029 hwdata SHALL be driven from the latched wdata in ARB_DATA.
REQ-030 On the edge where hready=1 in ARB_DATA, the block SHALL register hrdata into the granted rdata, set the granted done for the next cycle only, and set err=hresp.
REQ-031 Minimum latency SHALL be: request in cycle N, NONSEQ in N+1, DATA phase in N+2, done in N+3 (zero-wait slave).
REQ-032 The non-granted requester SHALL wait, with its done held low. It is served no earlier than the cycle after the current done.
REQ-033 If the requester deasserts req mid-transfer, the bus transfer SHALL still complete, and the done pulse is still emitted.
REQ-034 hresp=1 with hready=0 SHALL be treated as a wait state. No cancellation is performed.
REQ-035 i_done and d_done SHALL never be high in the same cycle.

Reset
REQ-036 While nRST=0, state=ARB_IDLE, htrans=IDLE, and haddr, hwrite, hsize, hwdata, all rdata, done and err outputs are 0; the RR pointer selects data.
REQ-037 Reset asserted mid-transfer SHALL abandon the transfer immediately (asynchronously), with no done pulse.

Configuration
REQ-038 With ARB_RR_EN defined, simultaneous requests SHALL alternate. The most recently served requester has lowest priority next, and the pointer updates on each done.
REQ-039 Without ARB_RR_EN, fixed data-over-instruction priority applies and no pointer register exists.

Structure
REQ-040 arb_state_t (ARB_IDLE, ARB_ADDR, ARB_DATA), the hsize constants (HSIZE_BYTE/HALF/WORD) and arb_grant_t (GRANT_I, GRANT_D) SHALL live in common_types_pkg, alongside htrans_t.
REQ-041 No sub-module is required; the priority select is inline logic.

Verification
REQ-042 i_req=1, i_addr=0x0000_0100, zero-wait slave, hrdata=0x0010_0093 -> NONSEQ at N+1, i_done=1 and i_rdata=0x0010_0093 at N+3.
REQ-043 d_req=1, d_wen=1, d_size=0, d_addr=0x2000_0003, d_wdata=0xAB -> hsize=0, hwrite=1, hwdata=0xAB in DATA, d_done at N+3.
REQ-044 i_req and d_req asserted together, no ARB_RR_EN -> data served first, i_done exactly 3 cycles after d_done. With ARB_RR_EN, held requests alternate D,I,D,I.
REQ-045 Slave inserts 2 wait states in DATA (hready=0,0,1) -> done at N+5, htrans=IDLE throughout.
REQ-046 Two-cycle error response (hresp=1,hready=0 then hresp=1,hready=1) on a data read -> d_done=1, d_err=1; the next request proceeds normally.
REQ-047 nRST pulled low during ARB_DATA -> htrans=IDLE and state ARB_IDLE immediately; no done pulse after release.
